// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Holds the FSM encoding, sizing helpers and the overflow rule.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  function automatic int nchunk(int w, int c);
    return (c < 1) ? 1 : w / c;
  endfunction

  // Index register is never narrower than one bit, even for NCHUNK=1.
  function automatic int idx_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic ovf_f(
    logic a_msb,
    logic b_msb,
    logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit ripple slice used once per CALC cycle.
// The carry between slices is held in a flop by the caller.
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  assign {co, sum} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};

endmodule

// File: rtl/adder_seq_chunked.sv
// Multi-cycle add/sub: one CHUNK-bit slice per clock, carry in a flop.
// Valid/ready on both sides; one bubble cycle per operation.
import adder_pkg::*;

module adder_seq_chunked #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_w(NCHUNK);
  localparam int MSB    = WIDTH - 1;
  localparam int CDIV   = (CHUNK < 1) ? 1 : CHUNK;

  if ((CHUNK < 1) || ((WIDTH % CDIV) != 0)) begin : g_bad_cfg
    $error("adder_seq_chunked: WIDTH must be a multiple of CHUNK >= 1");
  end

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_c;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_calc;
  logic             w_last;
  logic [CHUNK-1:0] w_xa;
  logic [CHUNK-1:0] w_xb;
  logic [CHUNK-1:0] w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_full;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_calc   = (r_state == CALC);
  assign w_last   = (r_idx == IW'(NCHUNK - 1));

  always_comb begin
    w_xa = r_a[int'(r_idx) * CHUNK +: CHUNK];
    w_xb = r_b[int'(r_idx) * CHUNK +: CHUNK];
  end

  add_chunk #(
    .W (CHUNK)
  ) u_add (
    .x   (w_xa),
    .y   (w_xb),
    .ci  (r_c),
    .sum (w_sum),
    .co  (w_co)
  );

  // Partial result with the current slice merged in, so the last
  // CALC edge can load s including its own chunk.
  always_comb begin
    w_full = r_part;
    w_full[int'(r_idx) * CHUNK +: CHUNK] = w_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)  w_next = CALC;
      CALC:    if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_part <= '0;
      r_c    <= 1'b0;
      r_idx  <= '0;
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= sub ? ~b : b;
      r_c   <= cin;
      r_idx <= '0;
    end else if (w_calc) begin
      r_part <= w_full;
      r_c    <= w_co;
      r_idx  <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) begin
        r_s    <= w_full;
        r_cout <= w_co;
        r_ovf  <= ovf_f(r_a[MSB], r_b[MSB], w_full[MSB]);
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_adder_seq_chunked.sv
// Scoreboard bench: 8/4 directed DUT plus 16-bit CHUNK=1/4/16 sweep.
// Stimulus pushes expectations; one monitor process does all compares.
module tb_adder_seq_chunked;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          acc;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } dchk_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] s;
  logic       cout;
  logic       ovf;

  adder_seq_chunked #(.WIDTH(8), .CHUNK(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  logic        sw_iv = 1'b0;
  logic [15:0] sw_a = '0;
  logic [15:0] sw_b = '0;
  logic        sw_cin = 1'b0;
  logic        sw_sub = 1'b0;
  logic        sw_ir[3];
  logic        sw_ov[3];
  logic        sw_co[3];
  logic        sw_of[3];
  logic [15:0] sw_s[3];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    adder_seq_chunked #(.WIDTH(16), .CHUNK(CH)) u_sw (
      .clk(clk), .rst(rst),
      .in_valid(sw_iv), .in_ready(sw_ir[g]),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
      .out_valid(sw_ov[g]), .out_ready(1'b1),
      .s(sw_s[g]), .cout(sw_co[g]), .ovf(sw_of[g])
    );
  end

  exp_t  mq[$];
  exp_t  sq[3][$];
  dchk_t dq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   errors = 0;
  logic ov_prev = 1'b0;
  int   rise_cyc = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    dchk_t d;
    exp_t  e;
    int    lat;
    while (dq.size() > 0) begin
      d = dq.pop_front();
      cmp(d.nm, d.act, d.exp);
    end
    if (!rst) begin
      if (out_valid && !ov_prev) rise_cyc = cyc;
      ov_prev = out_valid;
      if (out_valid && out_ready) begin
        if (mq.size() == 0) begin
          cmp("main_unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = mq.pop_front();
          cmp("main_s", 32'(s), 32'(e.s));
          cmp("main_cout", 32'(cout), 32'(e.co));
          cmp("main_ovf", 32'(ovf), 32'(e.ov));
          cmp("main_latency", 32'(rise_cyc - e.acc), 32'd2);
        end
      end
      for (int i = 0; i < 3; i++) begin
        lat = (i == 0) ? 16 : ((i == 1) ? 4 : 1);
        if (sw_ov[i]) begin
          if (sq[i].size() == 0) begin
            cmp($sformatf("sw%0d_unexpected", i), 32'd1, 32'd0);
          end else begin
            e = sq[i].pop_front();
            cmp($sformatf("sw%0d_s", i), 32'(sw_s[i]), 32'(e.s));
            cmp($sformatf("sw%0d_cout", i), 32'(sw_co[i]), 32'(e.co));
            cmp($sformatf("sw%0d_ovf", i), 32'(sw_of[i]), 32'(e.ov));
            cmp($sformatf("sw%0d_lat", i), 32'(cyc - e.acc), 32'(lat));
          end
        end
      end
    end else begin
      ov_prev = 1'b0;
    end
  end

  task automatic dchk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
    dchk_t d;
    d.nm = nm; d.act = act; d.exp = exp;
    dq.push_back(d);
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      $display("FAIL main_idle_timeout: got in_ready=0 expected 1");
      $fatal(1, "timeout");
    end
  endtask

  task automatic issue8(input logic [7:0] ia, ib, input logic ic, isub,
                        input logic [7:0] es, input logic eco, eov,
                        input bit push);
    exp_t e;
    wait_idle8();
    a = ia; b = ib; cin = ic; sub = isub;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'hA5; b = 8'h5A;
    if (push) begin
      e.s = {8'h00, es}; e.co = eco; e.ov = eov; e.acc = cyc;
      mq.push_back(e);
    end
    dchk("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  function automatic exp_t model16(input logic [15:0] x, y,
                                   input logic c, sb, input int acc);
    exp_t e;
    int   sx, sy, r, u;
    sx = {{16{x[15]}}, x};
    sy = {{16{y[15]}}, y};
    if (!sb) begin
      u = int'(x) + int'(y) + int'(c);
      r = sx + sy + int'(c);
      e.co = (u > 65535);
    end else begin
      u = int'(x) - int'(y) - (1 - int'(c));
      r = sx - sy - (1 - int'(c));
      e.co = (u >= 0);
    end
    e.s = u[15:0];
    e.ov = (r > 32767) || (r < -32768);
    e.acc = acc;
    return e;
  endfunction

  task automatic wait_sw_idle();
    int n = 0;
    while (!(sw_ir[0] && sw_ir[1] && sw_ir[2]) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!(sw_ir[0] && sw_ir[1] && sw_ir[2])) begin
      $display("FAIL sweep_idle_timeout: got busy expected idle");
      $fatal(1, "timeout");
    end
  endtask

  task automatic issue16(input logic [15:0] x, y, input logic c, sb);
    exp_t e;
    wait_sw_idle();
    sw_a = x; sw_b = y; sw_cin = c; sw_sub = sb;
    sw_iv = 1'b1;
    @(posedge clk); #1;
    sw_iv = 1'b0;
    sw_a = ~x; sw_b = ~y;
    e = model16(x, y, c, sb, cyc);
    for (int i = 0; i < 3; i++) sq[i].push_back(e);
  endtask

  initial begin
    int n;
    #12;
    dchk("rst_in_ready", 32'(in_ready), 32'd1);
    dchk("rst_out_valid", 32'(out_valid), 32'd0);
    dchk("rst_s", 32'(s), 32'd0);
    dchk("rst_cout", 32'(cout), 32'd0);
    dchk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    issue8(8'd5,   8'd6,   1'b0, 1'b0, 8'd11,  1'b0, 1'b0, 1);
    issue8(8'd255, 8'd0,   1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1);
    issue8(8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 1);
    issue8(8'd9,   8'd9,   1'b1, 1'b1, 8'd0,   1'b1, 1'b0, 1);
    issue8(8'd3,   8'd9,   1'b1, 1'b1, 8'd250, 1'b0, 1'b0, 1);
    issue8(8'd128, 8'd1,   1'b1, 1'b1, 8'd127, 1'b1, 1'b1, 1);
    wait_idle8();
    dchk("idle_after_ops", 32'(in_ready), 32'd1);

    // Backpressure: result must hold, new operands must be ignored
    out_ready = 1'b0;
    issue8(8'd100, 8'd50, 1'b0, 1'b0, 8'd150, 1'b0, 1'b1, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    repeat (5) begin
      dchk("bp_out_valid", 32'(out_valid), 32'd1);
      dchk("bp_s", 32'(s), 32'd150);
      dchk("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1; a = 8'd1; b = 8'd2;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    dchk("bp_release_out_valid", 32'(out_valid), 32'd0);
    dchk("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of CALC, between clock edges
    issue8(8'd20, 8'd30, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    dchk("midrst_out_valid", 32'(out_valid), 32'd0);
    dchk("midrst_in_ready", 32'(in_ready), 32'd1);
    dchk("midrst_s", 32'(s), 32'd0);
    dchk("midrst_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    dchk("postrst_out_valid", 32'(out_valid), 32'd0);
    issue8(8'd200, 8'd100, 1'b0, 1'b0, 8'd44, 1'b1, 1'b0, 1);
    wait_idle8();

    issue16(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    issue16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    issue16(16'h8000, 16'h0001, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      issue16(16'($urandom), 16'($urandom), 1'($urandom),
              1'(k % 2));
    end
    wait_sw_idle();
    repeat (2) @(posedge clk);
    #1;

    dchk("main_pending", 32'(mq.size()), 32'd0);
    for (int i = 0; i < 3; i++)
      dchk($sformatf("sw%0d_pending", i), 32'(sq[i].size()), 32'd0);
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
